jt12_acc_seq: RTL

//  Slot sequencer and channel-config scheduler for the operator accumulator.

---
 rtl/jt12_acc_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/jt12_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_acc_seq
//  Purpose  : Slot sequencer and channel-config scheduler for the operator
//             accumulator. Walks the operator groups in the order
//             S1,S3,S2,S4, with CHANNELS slots per group. For every slot it
//             emits the one-hot sN_enters strobes, ch6op, cur_ch, frame_end
//             and the active alg/rl of the current channel. Host config
//             writes are staged and become active only at the frame
//             boundary.
//  Params   : CHANNELS - channels per operator group (1..8)
//             PIPE     - extra cen-qualified output register stages (0..3)
//  Ports    : clk, rst (sync, active high), cen (slot advance enable)
//             cfg_we/cfg_ch/cfg_alg/cfg_rl - config write port (every clk)
//             s1/s3/s2/s4_enters, ch6op, cur_ch, alg, rl, frame_end - slot outputs
//  Revision : 1.0 - initial release
// ============================================================================
module jt12_acc_seq #(
    parameter int CHANNELS = 6,
    parameter int PIPE     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [1:0] cfg_rl,
    output logic       s1_enters,
    output logic       s3_enters,
    output logic       s2_enters,
    output logic       s4_enters,
    output logic       ch6op,
    output logic [2:0] cur_ch,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       frame_end
);

    // Output bus layout: {frame_end, ch6op, s4, s2, s3, s1, cur_ch, alg, rl}
    localparam int         DW        = 14;
    localparam logic [2:0] LAST_CH   = 3'(CHANNELS - 1);
    localparam logic [1:0] LAST_GRP  = 2'd3;
    localparam logic [1:0] RL_RESET  = 2'b11;
    localparam logic [DW-1:0] DEC_RESET = {1'b0, 1'b0, 4'b0001, 3'd0, 3'd0, RL_RESET};

    // Slot counters: grp 0=S1, 1=S3, 2=S2, 3=S4
    logic [1:0] grp_q, grp_d;
    logic [2:0] ch_q, ch_d;

    logic [2:0] stg_alg_q [CHANNELS];
    logic [2:0] stg_alg_d [CHANNELS];
    logic [1:0] stg_rl_q  [CHANNELS];
    logic [1:0] stg_rl_d  [CHANNELS];
    logic [2:0] act_alg_q [CHANNELS];
    logic [2:0] act_alg_d [CHANNELS];
    logic [1:0] act_rl_q  [CHANNELS];
    logic [1:0] act_rl_d  [CHANNELS];

    logic [DW-1:0] dec_q, dec_d;
    logic [DW-1:0] out_bus;

    logic       wrap;
    logic       cfg_hit;
    logic [2:0] sel_alg;
    logic [1:0] sel_rl;
    logic [3:0] enters;

    always_comb begin
        // The cen edge that leaves the frame_end slot also commits staging.
        wrap    = cen && (grp_q == LAST_GRP) && (ch_q == LAST_CH);
        cfg_hit = cfg_we && ({1'b0, cfg_ch} < 4'(CHANNELS));

        grp_d = grp_q;
        ch_d  = ch_q;
        if (cen) begin
            if (ch_q == LAST_CH) begin
                ch_d  = 3'd0;
                grp_d = grp_q + 2'd1;
            end else begin
                ch_d  = ch_q + 3'd1;
            end
        end

        // Active is loaded from the already-updated staging value so a write
        // landing on the wrap edge takes effect in the frame just starting.
        for (int i = 0; i < CHANNELS; i++) begin
            stg_alg_d[i] = stg_alg_q[i];
            stg_rl_d[i]  = stg_rl_q[i];
            if (cfg_hit && (cfg_ch == 3'(i))) begin
                stg_alg_d[i] = cfg_alg;
                stg_rl_d[i]  = cfg_rl;
            end
            act_alg_d[i] = wrap ? stg_alg_d[i] : act_alg_q[i];
            act_rl_d[i]  = wrap ? stg_rl_d[i]  : act_rl_q[i];
        end

        sel_alg = 3'd0;
        sel_rl  = RL_RESET;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_d == 3'(i)) begin
                sel_alg = act_alg_d[i];
                sel_rl  = act_rl_d[i];
            end
        end

        enters = 4'b0001 << grp_d;

        // Decode of the slot being entered; held between cen edges.
        dec_d = dec_q;
        if (cen) begin
            dec_d = {(grp_d == LAST_GRP) && (ch_d == LAST_CH),
                     (ch_d == LAST_CH),
                     enters, ch_d, sel_alg, sel_rl};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q <= 2'd0;
            ch_q  <= 3'd0;
            dec_q <= DEC_RESET;
            for (int i = 0; i < CHANNELS; i++) begin
                stg_alg_q[i] <= 3'd0;
                stg_rl_q[i]  <= RL_RESET;
                act_alg_q[i] <= 3'd0;
                act_rl_q[i]  <= RL_RESET;
            end
        end else begin
            grp_q <= grp_d;
            ch_q  <= ch_d;
            dec_q <= dec_d;
            for (int i = 0; i < CHANNELS; i++) begin
                stg_alg_q[i] <= stg_alg_d[i];
                stg_rl_q[i]  <= stg_rl_d[i];
                act_alg_q[i] <= act_alg_d[i];
                act_rl_q[i]  <= act_rl_d[i];
            end
        end
    end

    generate
        if (PIPE > 0) begin : g_pipe
            logic [DW-1:0] pipe_q [PIPE];
            logic [DW-1:0] pipe_d [PIPE];

            always_comb begin
                pipe_d[0] = cen ? dec_q : pipe_q[0];
                for (int i = 1; i < PIPE; i++) begin
                    pipe_d[i] = cen ? pipe_q[i-1] : pipe_q[i];
                end
            end

            // Delay stages clear to zero so no enters strobe fires until
            // real slot data has propagated through.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign out_bus = pipe_q[PIPE-1];
        end else begin : g_nopipe
            assign out_bus = dec_q;
        end
    endgenerate

    assign {frame_end, ch6op, s4_enters, s2_enters, s3_enters, s1_enters,
            cur_ch, alg, rl} = out_bus;

endmodule
`default_nettype wire
